// File: rtl/de10_lite_qsys_pio_pkg.sv
// Shared constants for the DE10-Lite Qsys PIO with edge capture:
// register addresses, edge-type encodings and the Avalon data width.
package de10_lite_qsys_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/de10_lite_qsys_pio_sync.sv
// Multi-stage flip-flop synchroniser for asynchronous board inputs.
// Every stage clears to 0 so no edge is seen on the first cycles after reset.
module de10_lite_qsys_pio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync_q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign sync_q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/de10_lite_qsys_pio_ec.sv
// Avalon-MM PIO slave: output register with set/clear aliases, synchronised
// input readback, per-bit edge capture (W1C) and a maskable level interrupt.
module de10_lite_qsys_pio_ec
    import de10_lite_qsys_pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic              irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    if (WIDTH < DATA_W) begin : g_wd_hi
        logic unused_wd_hi;
        assign unused_wd_hi = ^writedata[DATA_W-1:WIDTH];
    end

    de10_lite_qsys_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port),
        .sync_q  (sync_q)
    );

    always_comb begin
        det = '0;
        case (EDGE_TYPE)
            EDGE_FALL: det = ~sync_q & prev_q;
            EDGE_ANY:  det = sync_q ^ prev_q;
            default:   det = sync_q & ~prev_q;
        endcase
    end

    assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? wd : '0;

    // A fresh edge ORs in after the W1C mask, so set wins on a collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
            irq_mask <= '0;
            edge_cap <= '0;
            prev_q   <= '0;
        end else begin
            prev_q   <= sync_q;
            edge_cap <= (edge_cap & ~cap_clr) | det;
            if (wr) begin
                case (address)
                    ADDR_DATA_OUT: data_out <= wd;
                    ADDR_IRQ_MASK: irq_mask <= wd;
                    ADDR_OUTSET:   data_out <= data_out | wd;
                    ADDR_OUTCLR:   data_out <= data_out & ~wd;
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA_OUT: readdata = DATA_W'(data_out);
            ADDR_DATA_IN:  readdata = DATA_W'(sync_q);
            ADDR_IRQ_MASK: readdata = DATA_W'(irq_mask);
            ADDR_EDGE_CAP: readdata = DATA_W'(edge_cap);
            default:       readdata = '0;
        endcase
    end

    assign out_port = data_out;
    assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_de10_lite_qsys_pio_ec.sv
// Directed bench for the edge-capture PIO: instance A is 8-bit rising-edge
// with reset value 0x5A, instance B is 4-bit any-edge.
module tb_de10_lite_qsys_pio_ec;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs_a, cs_b;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd_a, rd_b;
    logic [7:0]  in_a, out_a;
    logic [3:0]  in_b, out_b;
    logic        irq_a, irq_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    de10_lite_qsys_pio_ec #(
        .WIDTH(8), .EDGE_TYPE(0), .RESET_VALUE(8'h5A), .SYNC_STAGES(2)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in_a), .out_port(out_a), .irq(irq_a)
    );

    de10_lite_qsys_pio_ec #(
        .WIDTH(4), .EDGE_TYPE(2), .RESET_VALUE(4'h0), .SYNC_STAGES(2)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b),
        .in_port(in_b), .out_port(out_b), .irq(irq_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Called at a negedge; the following posedge samples the write.
    task automatic wr_bus(input bit b, input logic [2:0] a, input logic [31:0] d);
        cs_a      = ~b;
        cs_b      = b;
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        @(negedge clk);
        cs_a    = 1'b0;
        cs_b    = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd_chk(input bit b, input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check(tag, b ? rd_b : rd_a, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
        in_a      = '0;
        in_b      = '0;

        // Reset state
        @(negedge clk);
        check("rst_out_a", 32'(out_a), 32'h5A);
        check("rst_irq_a", 32'(irq_a), 32'h0);
        rd_chk(0, 3'd0, 32'h0000005A, "rst_rd0_a");
        rd_chk(0, 3'd2, 32'h0, "rst_rd2_a");
        rd_chk(0, 3'd3, 32'h0, "rst_rd3_a");
        @(negedge clk);
        reset_n = 1'b1;
        cycles(2);

        // Output set / clear
        wr_bus(0, 3'd0, 32'h0000000F);
        wr_bus(0, 3'd4, 32'h000000F0);
        wr_bus(0, 3'd5, 32'h00000003);
        check("setclr_out", 32'(out_a), 32'hFC);
        rd_chk(0, 3'd0, 32'h000000FC, "setclr_rd0");
        rd_chk(0, 3'd4, 32'h0, "rd_outset_zero");
        @(negedge clk);
        rd_chk(0, 3'd5, 32'h0, "rd_outclr_zero");
        rd_chk(0, 3'd6, 32'h0, "rd_unmapped");
        wr_bus(0, 3'd1, 32'hFFFFFFFF);
        wr_bus(0, 3'd7, 32'hFFFFFFFF);
        check("ro_write_out", 32'(out_a), 32'hFC);
        rd_chk(0, 3'd1, 32'h0, "ro_write_din");
        rd_chk(0, 3'd3, 32'h0, "ro_write_cap");
        @(negedge clk);

        // Rising capture, latency through two sync stages
        wr_bus(0, 3'd2, 32'h00000001);
        in_a = 8'h01;
        @(negedge clk);
        rd_chk(0, 3'd1, 32'h0, "rise_k_din");
        rd_chk(0, 3'd3, 32'h0, "rise_k_cap");
        @(negedge clk);
        rd_chk(0, 3'd1, 32'h1, "rise_k1_din");
        rd_chk(0, 3'd3, 32'h0, "rise_k1_cap");
        check("rise_k1_irq", 32'(irq_a), 32'h0);
        @(negedge clk);
        rd_chk(0, 3'd3, 32'h1, "rise_k2_cap");
        check("rise_k2_irq", 32'(irq_a), 32'h1);
        wr_bus(0, 3'd3, 32'h00000001);
        check("w1c_irq_fall", 32'(irq_a), 32'h0);
        rd_chk(0, 3'd3, 32'h0, "w1c_cap");
        @(negedge clk);
        in_a = 8'h00;
        cycles(4);
        rd_chk(0, 3'd3, 32'h0, "fall_no_cap");
        check("fall_no_irq", 32'(irq_a), 32'h0);

        // W1C colliding with a new edge: set wins
        in_a = 8'h01;
        cycles(2);
        wr_bus(0, 3'd3, 32'h00000001);
        rd_chk(0, 3'd3, 32'h1, "collide_cap");
        check("collide_irq", 32'(irq_a), 32'h1);
        @(negedge clk);
        wr_bus(0, 3'd3, 32'h00000001);
        rd_chk(0, 3'd3, 32'h0, "collide_clr_cap");
        check("collide_clr_irq", 32'(irq_a), 32'h0);
        @(negedge clk);

        // Pending unmasked capture, then unmask
        in_a = 8'h05;
        cycles(4);
        rd_chk(0, 3'd3, 32'h04, "unmasked_cap");
        check("unmasked_irq", 32'(irq_a), 32'h0);
        wr_bus(0, 3'd2, 32'h00000005);
        check("mask_irq", 32'(irq_a), 32'h1);
        rd_chk(0, 3'd2, 32'h05, "mask_rd");
        @(negedge clk);
        wr_bus(0, 3'd3, 32'hFFFFFFFF);
        rd_chk(0, 3'd3, 32'h0, "clr_all_cap");

        // Any-edge, 4-bit instance
        @(negedge clk);
        in_b = 4'hA;
        cycles(3);
        rd_chk(1, 3'd3, 32'hA, "any_cap_a");
        @(negedge clk);
        in_b = 4'h5;
        cycles(3);
        rd_chk(1, 3'd3, 32'hF, "any_cap_f");
        rd_chk(1, 3'd1, 32'h5, "any_din");
        check("any_irq_masked", 32'(irq_b), 32'h0);
        @(negedge clk);
        wr_bus(1, 3'd0, 32'hFFFFFFFF);
        check("b_out_trunc", 32'(out_b), 32'hF);
        rd_chk(1, 3'd0, 32'h0000000F, "b_rd0");
        wr_bus(1, 3'd3, 32'h00000003);
        rd_chk(1, 3'd3, 32'hC, "b_w1c_part");
        check("a_untouched_out", 32'(out_a), 32'hFC);

        // Reset in the middle of a capture
        @(negedge clk);
        in_a = 8'h00;
        cycles(4);
        in_a = 8'h01;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_async", 32'(out_a), 32'h5A);
        check("midrst_irq", 32'(irq_a), 32'h0);
        in_a = 8'h00;
        cycles(2);
        reset_n = 1'b1;
        cycles(4);
        rd_chk(0, 3'd3, 32'h0, "midrst_cap");
        check("midrst_irq_after", 32'(irq_a), 32'h0);
        rd_chk(0, 3'd2, 32'h0, "midrst_mask");
        check("midrst_out_after", 32'(out_a), 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
